// File: rtl/ext.sv
// Immediate extender: forms the selected immediate from instr[31:7] and
// registers it. Dout clears asynchronously on rst and holds while en is low.
module ext (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [2:0]  CEU,
   input  logic [24:0] Dint,
   output logic [31:0] Dout
);

   logic        s;
   logic [31:0] imm;

   assign s = Dint[24];

   always_comb begin
      imm = 32'h0000_0000;
      case (CEU)
         3'b000:  imm = {{20{s}}, Dint[24:13]};
         3'b001:  imm = {{20{s}}, Dint[24:18], Dint[4:0]};
         3'b010:  imm = {{19{s}}, s, Dint[0], Dint[23:18], Dint[4:1], 1'b0};
         3'b011:  imm = {Dint[24:5], 12'b0};
         3'b100:  imm = {{11{s}}, s, Dint[12:5], Dint[13], Dint[23:14], 1'b0};
         3'b101:  imm = {27'b0, Dint[17:13]};
         3'b110:  imm = {27'b0, Dint[12:8]};
         default: imm = 32'h0000_0000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         Dout <= 32'h0000_0000;
      else if (en)
         Dout <= imm;
   end

endmodule

// File: tb/tb_ext.sv
// Self-checking bench for ext: directed vectors plus randomized loads
// compared against a reference model built on the full 32-bit instruction.
module tb_ext;

   logic        clk;
   logic        rst;
   logic        en;
   logic [2:0]  CEU;
   logic [24:0] Dint;
   logic [31:0] Dout;

   int          n_tests;
   int          n_fail;
   logic [31:0] exp_q;

   ext u_ext (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .CEU  (CEU),
      .Dint (Dint),
      .Dout (Dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, want);
      end
   endtask

   // Reference immediate, from the architectural instruction layout.
   function automatic logic [31:0] ref_imm(input logic [2:0] sel, input logic [24:0] d);
      logic [31:0]        i;
      logic signed [11:0] f12;
      logic signed [12:0] f13;
      logic signed [20:0] f21;
      i = {d, 7'b0};
      case (sel)
         3'd0: begin f12 = i[31:20]; return 32'(f12); end
         3'd1: begin f12 = {i[31:25], i[11:7]}; return 32'(f12); end
         3'd2: begin f13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; return 32'(f13); end
         3'd3: return {i[31:12], 12'h000};
         3'd4: begin f21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; return 32'(f21); end
         3'd5: return 32'(i[24:20]);
         3'd6: return 32'(i[19:15]);
         default: return 32'd0;
      endcase
   endfunction

   // Clock one edge, update the model as the register should, settle.
   task automatic step();
      @(posedge clk);
      if (!rst && en) exp_q = ref_imm(CEU, Dint);
      #1;
   endtask

   logic [31:0] dir_exp [8];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      exp_q   = 32'd0;
      dir_exp = '{32'hFFFF_FAAA, 32'hFFFF_FAB5, 32'hFFFF_FAB4, 32'hAAAA_A000,
                  32'hFFFA_A2AA, 32'h0000_000A, 32'h0000_0015, 32'h0000_0000};
      rst  = 1'b1;
      en   = 1'b1;
      CEU  = 3'd0;
      Dint = 25'h155_5555;
      #2;
      chk("reset_async", Dout, 32'd0);
      step();
      chk("reset_hold_clk", Dout, 32'd0);
      #2 rst = 1'b0;
      #1 chk("reset_release", Dout, 32'd0);

      // All eight formats with alternating pattern, s=1
      for (int k = 0; k < 8; k++) begin
         CEU = 3'(k);
         step();
         chk($sformatf("pattern_ceu%0d", k), Dout, dir_exp[k]);
         chk($sformatf("model_ceu%0d", k), Dout, exp_q);
      end

      // Positive pattern, s=0
      Dint = 25'h0AA_AAAA;
      CEU  = 3'd0;
      step();
      chk("pos_itype", Dout, 32'h0000_0555);
      CEU = 3'd3;
      step();
      chk("pos_utype", Dout, 32'h5555_5000);

      // Hold while en is low
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         CEU  = 3'($urandom_range(0, 7));
         Dint = 25'($urandom);
         step();
         chk("hold_en0", Dout, 32'h5555_5000);
      end

      // New input only visible after the edge
      en   = 1'b1;
      CEU  = 3'd0;
      Dint = 25'h155_5555;
      #1 chk("latency_pre", Dout, 32'h5555_5000);
      step();
      chk("latency_post", Dout, 32'hFFFF_FAAA);

      // Reset mid-cycle clears immediately and discards pending value
      CEU  = 3'd3;
      Dint = 25'h0AA_AAAA;
      #1 rst = 1'b1;
      #1 chk("rst_midcycle", Dout, 32'd0);
      exp_q = 32'd0;
      step();
      chk("rst_over_edge", Dout, 32'd0);
      #1 rst = 1'b0;
      #1 chk("rst_deassert", Dout, 32'd0);
      CEU  = 3'd0;
      Dint = 25'h155_5555;
      step();
      chk("rst_reload", Dout, 32'hFFFF_FAAA);

      // Randomized loads against the model
      for (int k = 0; k < 300; k++) begin
         en   = ($urandom_range(0, 3) != 0);
         CEU  = 3'($urandom_range(0, 7));
         Dint = 25'($urandom);
         step();
         chk($sformatf("rand_ceu%0d", CEU), Dout, exp_q);
         if (CEU == 3'd2 || CEU == 3'd4)
            chk("rand_lsb0", {31'd0, Dout[0] & en}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
